ips2l_sgmii_sig_filter_stretch_v1_1: RTL and testbench
======================================================

Name: ips2l_sgmii_sig_filter_stretch_v1_1

Overview:
Multi-channel, single-clock conditioner for slow status and reset-type signals in the SGMII/QSGMII register-slave path, such as link, sync and PLL-lock flags. Each channel does the following, in order:
- synchronises its asynchronous input;
- rejects glitches shorter than a programmable sample count;
- stretches the active phase by a programmable number of cycles, so a downstream slower consumer cannot miss it.
It also provides a per-channel activation pulse and a stretch-tail indicator.

Parameters:
- CH_NUM, 4, number of independent channels (1..32).
- SYNC_STAGES, 2, synchroniser flop depth per channel (>=2).
- FILTER_LEN, 3, consecutive identical synchronised samples required before the filtered level changes (1..255).
- STRETCH_LEN, 5, extra active cycles held after the filtered level goes inactive (0..255; 0 = pure filter).
- ACTIVE_LEVEL, {CH_NUM{1'b1}}, per-channel active polarity: bit n = 1 means high-active, 0 means low-active.

Ports:
- i_clk  input  1  single clock; all logic on its rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_sig  input  CH_NUM  asynchronous raw signals, one bit per channel.
- o_sig  output  CH_NUM  conditioned signals, in the same polarity as i_sig (registered).
- o_sig_rise  output  CH_NUM  one-cycle pulse when o_sig[n] enters its active level (registered).
- o_busy  output  CH_NUM  high while channel n is in its stretch tail (registered).

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- While i_rst=1 at a rising edge, every register clears:
  - synchroniser flops load ~ACTIVE_LEVEL[n];
  - filt=0, fcnt=0, scnt=0;
  - o_sig=~ACTIVE_LEVEL, o_sig_rise=0, o_busy=0.
- Reset asserted mid-operation (mid-filter or mid-stretch) aborts immediately at that edge. No tail is completed.
- After reset release, an input that is already active is re-detected with the full latency.
- Per-channel datapath (channels fully independent):
  - s = i_sig[n] after SYNC_STAGES flops.
  - a = s XNOR ACTIVE_LEVEL[n]; a=1 means active.
- Filter. fcnt width is clog2(FILTER_LEN), minimum 1. At each edge:
  - if a==filt: fcnt<=0;
  - else if fcnt==FILTER_LEN-1: filt<=a and fcnt<=0;
  - else: fcnt<=fcnt+1.
  - Net effect: a run of a!=filt shorter than FILTER_LEN consecutive cycles leaves filt unchanged.
  - FILTER_LEN=1: filt follows a with a 1-cycle delay.
- Stretch. scnt width is clog2(STRETCH_LEN+1), minimum 1.
  - filt=1: scnt<=STRETCH_LEN.
  - filt=0 and scnt!=0: scnt<=scnt-1.
  - A new filt rise during the tail reloads the counter (retriggerable).
- Outputs:
  - act = filt | (scnt!=0).
  - o_sig[n] <= act ? ACTIVE_LEVEL[n] : ~ACTIVE_LEVEL[n].
  - o_sig_rise[n] <= act & ~act_q, where act_q is the previous registered act.
  - o_busy[n] <= ~filt & (scnt!=0).
- Latency: counting the first edge that samples a changed i_sig as edge 1:
  - filt changes at edge SYNC_STAGES+FILTER_LEN;
  - o_sig asserts at edge SYNC_STAGES+FILTER_LEN+1 (6 with defaults).
  - o_sig deasserts STRETCH_LEN edges later than a non-stretched version would.
- Minimum active width: a filtered pulse of W cycles gives an o_sig active width of W+STRETCH_LEN cycles.
- Boundary cases:
  - Input toggling every cycle with FILTER_LEN>=2: o_sig never changes.
  - STRETCH_LEN=0: o_busy is constant 0.
  - Counters saturate by construction: fcnt never exceeds FILTER_LEN-1 and scnt never exceeds STRETCH_LEN. No wrap-around.
- Parameters out of range are rejected at elaboration with $error.

Test Plan:
- Reset check (defaults): apply i_rst for 3 cycles with i_sig=4'hF. Required: o_sig=4'h0, o_sig_rise=0, o_busy=0 during reset. First o_sig[n]=1 at the 6th edge after release, with o_sig_rise pulsing at that same edge.
- Glitch reject: ch0 high for 2 cycles (FILTER_LEN=3) -> o_sig[0] stays 0, no rise pulse. High for 3 cycles -> o_sig[0] high for exactly 3+5=8 cycles, o_busy[0] high for the last 5 of them.
- Retrigger: ch1 filtered pulse, then a second 4-cycle pulse starting 2 cycles into the tail -> o_sig[1] never drops between pulses, a single rise pulse only, and the tail restarts at 5.
- Low-active channel (ACTIVE_LEVEL=4'b1110): i_sig[0] driven 1->0 for 4 cycles -> o_sig[0] goes low at edge 6 and returns high 4+5 cycles later. o_sig_rise[0] pulses on the falling transition.
- Reset mid-stretch: assert i_rst while o_busy[2]=1 with scnt=3 -> at that edge o_sig[2]=0 and o_busy[2]=0. With input inactive, no residual tail after release.
- Parameter corners: STRETCH_LEN=0 and FILTER_LEN=1 with SYNC_STAGES=3 -> o_sig mirrors i_sig delayed by exactly 5 edges, and o_busy is constant 0. Random multi-channel stimulus is checked against a reference model with no cross-channel interaction.

Source files
------------

// File: rtl/ips2l_sgmii_sig_filter_stretch_v1_1.sv
// Purpose: per-channel sync, glitch filter and stretcher for slow SGMII status/reset flags.
// Latency: o_sig follows an input change after SYNC_STAGES+FILTER_LEN+1 edges; the trailing edge is held STRETCH_LEN extra.
// Backpressure: none; the block samples every cycle and never stalls.
module ips2l_sgmii_sig_filter_stretch_v1_1 #(
    parameter int                  CH_NUM       = 4,
    parameter int                  SYNC_STAGES  = 2,
    parameter int                  FILTER_LEN   = 3,
    parameter int                  STRETCH_LEN  = 5,
    parameter logic [CH_NUM-1:0]   ACTIVE_LEVEL = {CH_NUM{1'b1}}
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [CH_NUM-1:0] i_sig,
    output logic [CH_NUM-1:0] o_sig,
    output logic [CH_NUM-1:0] o_sig_rise,
    output logic [CH_NUM-1:0] o_busy
);

    localparam int FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int SCNT_W = (STRETCH_LEN > 0) ? $clog2(STRETCH_LEN + 1) : 1;
    localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(FILTER_LEN - 1);
    localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'(STRETCH_LEN);

    // Out-of-range parameters would silently truncate the counters, so stop elaboration instead.
    if (CH_NUM < 1 || CH_NUM > 32) begin : g_bad_ch_num
        $error("CH_NUM must be within 1..32");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("SYNC_STAGES must be at least 2");
    end
    if (FILTER_LEN < 1 || FILTER_LEN > 255) begin : g_bad_filter_len
        $error("FILTER_LEN must be within 1..255");
    end
    if (STRETCH_LEN < 0 || STRETCH_LEN > 255) begin : g_bad_stretch_len
        $error("STRETCH_LEN must be within 0..255");
    end

    logic [SYNC_STAGES-1:0][CH_NUM-1:0] sync_q, sync_d;
    logic [CH_NUM-1:0]                  filt_q, filt_d;
    logic [CH_NUM-1:0][FCNT_W-1:0]      fcnt_q, fcnt_d;
    logic [CH_NUM-1:0][SCNT_W-1:0]      scnt_q, scnt_d;
    logic [CH_NUM-1:0]                  act_q, act_d;
    logic [CH_NUM-1:0]                  sig_q, sig_d;
    logic [CH_NUM-1:0]                  rise_q, rise_d;
    logic [CH_NUM-1:0]                  busy_q, busy_d;
    logic [CH_NUM-1:0]                  samp_act;

    // Shift the raw inputs through the synchroniser chain.
    always_comb begin
        sync_d[0] = i_sig;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Normalise polarity so the rest of the datapath treats 1 as active on every channel.
    always_comb begin
        samp_act = ~(sync_q[SYNC_STAGES-1] ^ ACTIVE_LEVEL);
    end

    // Glitch filter, stretch counter and output shaping, one independent lane per channel.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = fcnt_q;
        scnt_d = scnt_q;
        act_d  = act_q;
        sig_d  = sig_q;
        rise_d = rise_q;
        busy_d = busy_q;
        for (int n = 0; n < CH_NUM; n++) begin
            // A disagreeing sample run must reach FILTER_LEN before the level flips;
            // the counter clears on any agreeing sample so it can never exceed FCNT_MAX.
            if (samp_act[n] == filt_q[n]) begin
                fcnt_d[n] = '0;
            end else if (fcnt_q[n] == FCNT_MAX) begin
                filt_d[n] = samp_act[n];
                fcnt_d[n] = '0;
            end else begin
                fcnt_d[n] = fcnt_q[n] + FCNT_W'(1);
            end

            // Held at full length while active so a re-rise mid-tail restarts the tail.
            if (filt_q[n]) begin
                scnt_d[n] = SCNT_MAX;
            end else if (scnt_q[n] != '0) begin
                scnt_d[n] = scnt_q[n] - SCNT_W'(1);
            end

            act_d[n]  = filt_q[n] | (scnt_q[n] != '0);
            sig_d[n]  = ~(act_d[n] ^ ACTIVE_LEVEL[n]);
            rise_d[n] = act_d[n] & ~act_q[n];
            busy_d[n] = ~filt_q[n] & (scnt_q[n] != '0);
        end
    end

    // State registers; reset drops any filter run or stretch tail in progress.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= {SYNC_STAGES{~ACTIVE_LEVEL}};
            filt_q <= '0;
            fcnt_q <= '0;
            scnt_q <= '0;
            act_q  <= '0;
            sig_q  <= ~ACTIVE_LEVEL;
            rise_q <= '0;
            busy_q <= '0;
        end else begin
            sync_q <= sync_d;
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
            scnt_q <= scnt_d;
            act_q  <= act_d;
            sig_q  <= sig_d;
            rise_q <= rise_d;
            busy_q <= busy_d;
        end
    end

    assign o_sig      = sig_q;
    assign o_sig_rise = rise_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_ips2l_sgmii_sig_filter_stretch_v1_1.sv
// Purpose: scoreboard bench for the signal filter/stretcher across three parameter sets.
// Latency: expectations are keyed to the edge count at which each output value is due.
// Backpressure: not applicable; outputs are checked every cycle an expectation is due.
module tb_ips2l_sgmii_sig_filter_stretch_v1_1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       a_rst, b_rst, c_rst;
    logic [3:0] a_sig, b_sig, c_sig;
    logic [3:0] a_o, a_rise, a_busy;
    logic [3:0] b_o, b_rise, b_busy;
    logic [3:0] c_o, c_rise, c_busy;

    // Defaults: high-active, 2 sync stages, filter 3, stretch 5.
    ips2l_sgmii_sig_filter_stretch_v1_1 u_dut_a (
        .i_clk(clk), .i_rst(a_rst), .i_sig(a_sig),
        .o_sig(a_o), .o_sig_rise(a_rise), .o_busy(a_busy)
    );

    // Channel 0 low-active.
    ips2l_sgmii_sig_filter_stretch_v1_1 #(.ACTIVE_LEVEL(4'b1110)) u_dut_b (
        .i_clk(clk), .i_rst(b_rst), .i_sig(b_sig),
        .o_sig(b_o), .o_sig_rise(b_rise), .o_busy(b_busy)
    );

    // Pure delay corner: 3 sync stages, no filtering, no stretch.
    ips2l_sgmii_sig_filter_stretch_v1_1 #(.SYNC_STAGES(3), .FILTER_LEN(1), .STRETCH_LEN(0)) u_dut_c (
        .i_clk(clk), .i_rst(c_rst), .i_sig(c_sig),
        .o_sig(c_o), .o_sig_rise(c_rise), .o_busy(c_busy)
    );

    typedef struct {
        int         at;
        int         dut;
        int         kind;
        logic [3:0] mask;
        logic [3:0] val;
        string      name;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic expect_at(input int at, input int dut, input int kind,
                             input logic [3:0] mask, input logic [3:0] val, input string name);
        exp_t e;
        e.at = at; e.dut = dut; e.kind = kind; e.mask = mask; e.val = val; e.name = name;
        sbq.push_back(e);
    endtask

    task automatic expect_span(input int from, input int to, input int dut, input int kind,
                               input logic [3:0] mask, input logic [3:0] val, input string name);
        for (int k = from; k <= to; k++) expect_at(k, dut, kind, mask, val, name);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] dut_out(input int dut, input int kind);
        logic [3:0] r;
        r = 4'h0;
        case (dut * 3 + kind)
            0: r = a_o;   1: r = a_rise; 2: r = a_busy;
            3: r = b_o;   4: r = b_rise; 5: r = b_busy;
            6: r = c_o;   7: r = c_rise; 8: r = c_busy;
            default: r = 4'hx;
        endcase
        return r;
    endfunction

    // Monitor: on every falling edge, retire all expectations that are due.
    always @(negedge clk) begin
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].at <= cyc) begin
                logic [3:0] got;
                got = dut_out(sbq[i].dut, sbq[i].kind) & sbq[i].mask;
                total++;
                if (sbq[i].at != cyc || got !== (sbq[i].val & sbq[i].mask)) begin
                    bad++;
                    $display("FAIL %s cyc=%0d due=%0d got=%b want=%b",
                             sbq[i].name, cyc, sbq[i].at, got, sbq[i].val & sbq[i].mask);
                end
                sbq.delete(i);
            end
        end
    end

    initial begin
        int b;
        logic [3:0] v, prev;

        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
        a_sig = 4'hF; b_sig = 4'b0001; c_sig = 4'h0;

        // Reset state: inactive levels while reset is held with active inputs.
        expect_span(1, 3, 0, 0, 4'hF, 4'h0, "a_rst_osig");
        expect_span(1, 3, 0, 1, 4'hF, 4'h0, "a_rst_rise");
        expect_span(1, 3, 0, 2, 4'hF, 4'h0, "a_rst_busy");
        expect_span(1, 3, 1, 0, 4'hF, 4'b0001, "b_rst_osig");
        wait_cyc(3);
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

        // Already-active input is re-detected with the full latency: 6th edge after release.
        expect_span(4, 8, 0, 0, 4'hF, 4'h0, "a_pre_osig");
        expect_at(9, 0, 0, 4'hF, 4'hF, "a_first_osig");
        expect_at(9, 0, 1, 4'hF, 4'hF, "a_first_rise");
        expect_at(10, 0, 1, 4'hF, 4'h0, "a_rise_once");
        expect_span(10, 20, 0, 0, 4'hF, 4'hF, "a_hold_osig");
        wait_cyc(7);
        a_sig = 4'h0;
        // Drop at 10: filt falls at 15, o_sig held through 20, tail busy 16..20.
        expect_span(10, 15, 0, 2, 4'hF, 4'h0, "a_busy_pre");
        expect_span(16, 20, 0, 2, 4'hF, 4'hF, "a_tail_busy");
        expect_at(21, 0, 0, 4'hF, 4'h0, "a_tail_end_osig");
        expect_at(21, 0, 2, 4'hF, 4'h0, "a_tail_end_busy");
        wait_cyc(15);

        // Glitch of 2 cycles on ch0 is rejected.
        b = cyc;
        a_sig[0] = 1'b1;
        expect_span(b + 1, b + 12, 0, 0, 4'b0001, 4'h0, "glitch_osig");
        expect_span(b + 1, b + 12, 0, 1, 4'b0001, 4'h0, "glitch_rise");
        wait_cyc(2);
        a_sig[0] = 1'b0;
        wait_cyc(12);

        // 3-cycle pulse on ch0: o_sig high 8 cycles, busy the last 5.
        b = cyc;
        a_sig[0] = 1'b1;
        expect_at(b + 5, 0, 0, 4'b0001, 4'h0, "p3_osig_before");
        expect_span(b + 6, b + 13, 0, 0, 4'b0001, 4'b0001, "p3_osig_high");
        expect_at(b + 14, 0, 0, 4'b0001, 4'h0, "p3_osig_after");
        expect_at(b + 6, 0, 1, 4'b0001, 4'b0001, "p3_rise");
        expect_at(b + 7, 0, 1, 4'b0001, 4'h0, "p3_rise_end");
        expect_span(b + 6, b + 8, 0, 2, 4'b0001, 4'h0, "p3_busy_early");
        expect_span(b + 9, b + 13, 0, 2, 4'b0001, 4'b0001, "p3_busy_tail");
        expect_at(b + 14, 0, 2, 4'b0001, 4'h0, "p3_busy_after");
        wait_cyc(3);
        a_sig[0] = 1'b0;
        wait_cyc(14);

        // Retrigger on ch1: second filtered pulse arrives during the tail.
        b = cyc;
        a_sig[1] = 1'b1;
        expect_at(b + 5, 0, 0, 4'b0010, 4'h0, "rt_osig_before");
        expect_span(b + 6, b + 20, 0, 0, 4'b0010, 4'b0010, "rt_osig_held");
        expect_at(b + 21, 0, 0, 4'b0010, 4'h0, "rt_osig_after");
        expect_at(b + 6, 0, 1, 4'b0010, 4'b0010, "rt_rise");
        expect_span(b + 7, b + 21, 0, 1, 4'b0010, 4'h0, "rt_single_rise");
        expect_span(b + 9, b + 11, 0, 2, 4'b0010, 4'b0010, "rt_busy_first");
        expect_span(b + 12, b + 15, 0, 2, 4'b0010, 4'h0, "rt_busy_gap");
        expect_span(b + 16, b + 20, 0, 2, 4'b0010, 4'b0010, "rt_busy_full_tail");
        expect_at(b + 21, 0, 2, 4'b0010, 4'h0, "rt_busy_after");
        wait_cyc(3);
        a_sig[1] = 1'b0;
        wait_cyc(3);
        a_sig[1] = 1'b1;
        wait_cyc(4);
        a_sig[1] = 1'b0;
        wait_cyc(15);

        // Reset mid-stretch on ch2 while the tail counter is at 3.
        b = cyc;
        a_sig[2] = 1'b1;
        expect_span(b + 9, b + 10, 0, 2, 4'b0100, 4'b0100, "rm_busy_in_tail");
        expect_at(b + 10, 0, 0, 4'b0100, 4'b0100, "rm_osig_in_tail");
        expect_at(b + 11, 0, 0, 4'hF, 4'h0, "rm_osig_abort");
        expect_at(b + 11, 0, 2, 4'hF, 4'h0, "rm_busy_abort");
        expect_at(b + 11, 0, 1, 4'hF, 4'h0, "rm_rise_abort");
        expect_span(b + 12, b + 22, 0, 0, 4'hF, 4'h0, "rm_osig_no_tail");
        expect_span(b + 12, b + 22, 0, 2, 4'hF, 4'h0, "rm_busy_no_tail");
        wait_cyc(3);
        a_sig[2] = 1'b0;
        wait_cyc(7);
        a_rst = 1'b1;
        wait_cyc(1);
        a_rst = 1'b0;
        wait_cyc(12);

        // Low-active ch0 on DUT B: 4-cycle low pulse gives 9 cycles of low output.
        b = cyc;
        b_sig[0] = 1'b0;
        expect_at(b + 5, 1, 0, 4'b0001, 4'b0001, "la_osig_before");
        expect_span(b + 6, b + 14, 1, 0, 4'b0001, 4'h0, "la_osig_active");
        expect_at(b + 15, 1, 0, 4'b0001, 4'b0001, "la_osig_after");
        expect_at(b + 6, 1, 1, 4'b0001, 4'b0001, "la_rise");
        expect_at(b + 7, 1, 1, 4'b0001, 4'h0, "la_rise_end");
        expect_at(b + 9, 1, 2, 4'b0001, 4'h0, "la_busy_early");
        expect_span(b + 10, b + 14, 1, 2, 4'b0001, 4'b0001, "la_busy_tail");
        expect_at(b + 15, 1, 2, 4'b0001, 4'h0, "la_busy_after");
        expect_at(b + 10, 1, 0, 4'b1110, 4'h0, "la_other_ch");
        wait_cyc(4);
        b_sig[0] = 1'b1;
        wait_cyc(17);

        // DUT C: random multi-channel input must reappear exactly 5 edges later, busy never set.
        prev = 4'h0;
        for (int k = 0; k < 200; k++) begin
            v = 4'($urandom_range(0, 15));
            c_sig = v;
            expect_at(cyc + 5, 2, 0, 4'hF, v, "c_osig_delay");
            expect_at(cyc + 5, 2, 1, 4'hF, v & ~prev, "c_rise");
            expect_at(cyc + 5, 2, 2, 4'hF, 4'h0, "c_busy_zero");
            prev = v;
            wait_cyc(1);
        end

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 40 && sbq.size() > 0; k++) wait_cyc(1);
        if (sbq.size() > 0) begin
            $display("FAIL drain pending=%0d want=0", sbq.size());
            bad += sbq.size();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
